// File: rtl/ld2_bank_writer.sv
// Write-port sequencer for a bank of active-low-gated transparent latches.
// Data is set up, one gate (or all of them) opens for PULSE cycles, then the gate closes and data is held.
module ld2_bank_writer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int PULSE = 1
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             REQ,
  input  logic             BCAST,
  input  logic [AW-1:0]    ADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic             BUSY,
  output logic             ACK,
  output logic             ERR,
  output logic [WIDTH-1:0] D,
  output logic [DEPTH-1:0] GN
);

  localparam int          CW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam int unsigned NW = DEPTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_addr;
  logic             r_bcast;
  logic             r_err;
  logic             w_addr_ok;
  logic [DEPTH-1:0] w_open_mask;

  // A full bank cannot be addressed out of range.
  if (DEPTH >= (1 << AW)) begin : g_full
    assign w_addr_ok = 1'b1;
  end else begin : g_part
    assign w_addr_ok = (r_addr < AW'(DEPTH));
  end

  always_comb begin
    w_open_mask = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      w_open_mask[j] = r_bcast || (w_addr_ok && (r_addr == AW'(j)));
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_bcast <= 1'b0;
      r_err   <= 1'b0;
      BUSY    <= 1'b0;
      ACK     <= 1'b0;
      ERR     <= 1'b0;
      D       <= '0;
      GN      <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          ACK <= 1'b0;
          ERR <= 1'b0;
          if (REQ) begin
            r_addr  <= ADDR;
            r_bcast <= BCAST;
            D       <= WDATA;
            BUSY    <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          GN      <= ~w_open_mask;
          r_err   <= !w_addr_ok && !r_bcast;
          r_cnt   <= CW'(PULSE - 1);
          r_state <= S_OPEN;
        end
        S_OPEN: begin
          if (r_cnt == '0) begin
            GN      <= '1;
            ACK     <= 1'b1;
            ERR     <= r_err;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          ACK     <= 1'b0;
          ERR     <= 1'b0;
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          GN      <= '1;
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
